frame_capture_s_axis: RTL and testbench
=======================================

Name: frame_capture_s_axis

Overview:
AXI-Stream slave that receives fixed-length 64-bit I/Q sample frames, such as the noise-injected stream from the channel-sounder datapath. It writes each frame into a two-bank (ping-pong) BRAM region through a simple write port. Completed banks are handed to the PS/DMA side by a done pulse and a full flag, and are returned by a release pulse. Frame-length violations are detected, the offending frame is discarded, and a sticky error flag is set.

Parameters:
- BRAM_DEPTH_BITS, 11, BRAM address width; must satisfy 2*FRAME_WORDS <= 2^BRAM_DEPTH_BITS
- C_S_AXIS_TDATA_WIDTH, 64, stream and BRAM data width; {Q[63:32], I[31:0]}
- FRAME_WORDS, 1024, words per frame; TLAST is expected on word FRAME_WORDS-1

Ports:
- S_AXIS_ACLK  in  1  clock
- S_AXIS_ARESETN  in  1  synchronous active-low reset
- S_AXIS_TVALID  in  1  stream valid
- S_AXIS_TDATA  in  64  stream data
- S_AXIS_TSTRB  in  8  byte strobes; ignored
- S_AXIS_TLAST  in  1  end of frame
- S_AXIS_TREADY  out  1  stream ready
- ENABLE  in  1  level; capture allowed while high
- BANK_RELEASE  in  2  one-cycle pulse per bank; clears that bank's full flag
- CLEAR_ERR  in  1  pulse; clears sticky errors
- BRAM_ADDR  out  BRAM_DEPTH_BITS  write address
- BRAM_DATAOUT  out  64  write data
- BRAM_WE  out  1  write enable
- FRAME_DONE  out  1  one-cycle pulse when a bank has been completely written
- DONE_BANK  out  1  bank index, valid while FRAME_DONE is high
- BANK_FULL  out  2  per-bank full flags
- FRAME_COUNT  out  32  good frames captured; wraps modulo 2^32
- ERR_SHORT  out  1  sticky: TLAST arrived before word FRAME_WORDS-1
- ERR_LONG  out  1  sticky: no TLAST on word FRAME_WORDS-1
- FRAME_SUM  out  32  per-frame checksum (see Optional Feature)

Behaviour:
- Reset state: every output is 0, state IDLE, active bank 0, word counter 0, both banks empty.
- Handshake: a word transfers on TVALID & TREADY.
  - TREADY is combinational from registered state only; it never depends on TVALID.
- States:
  - IDLE: TREADY=0. Go to CAPTURE when ENABLE=1 and the active bank is empty. Go to WAIT_BANK when ENABLE=1 and the active bank is full.
  - CAPTURE: TREADY=1. Each transfer writes one word.
  - DROP: TREADY=1. No BRAM writes. Stay until a transfer with TLAST=1, then move to CAPTURE on the same bank with the counter at 0.
  - WAIT_BANK: TREADY=0 until the active bank's full flag clears. TREADY rises the cycle after the BANK_RELEASE pulse.
- Write pipeline, latency 1:
  - In the cycle after a transfer: BRAM_WE=1, BRAM_DATAOUT = TDATA, BRAM_ADDR = active_bank*FRAME_WORDS + word_ctr.
  - Back-to-back transfers give back-to-back writes.
- Counter: word_ctr increments on each CAPTURE transfer.
- Good frame (TLAST on word FRAME_WORDS-1):
  - FRAME_DONE=1 in the cycle after the last BRAM_WE, with DONE_BANK equal to the completed bank.
  - The same cycle sets BANK_FULL[bank], increments FRAME_COUNT, toggles the active bank, and resets word_ctr to 0.
  - Next state: WAIT_BANK if the new bank is full; IDLE if ENABLE=0; otherwise CAPTURE.
- Short frame (TLAST at word_ctr < FRAME_WORDS-1):
  - The word is still written. ERR_SHORT is set.
  - The bank is not marked full, FRAME_DONE is not pulsed, word_ctr returns to 0 and the same bank is reused.
- Long frame (TLAST=0 on word FRAME_WORDS-1):
  - That word is written. ERR_LONG is set, the state goes to DROP, and the bank is not marked full.
- ENABLE deasserted mid-frame: the current frame (or DROP) completes normally, then the block goes to IDLE.
- CLEAR_ERR in the same cycle as a new error: the set wins.
- BANK_RELEASE for a bank that is not full: no effect. A release and a set in the same cycle cannot target the same bank, because the active bank is never full while capturing.
- Reset mid-frame: all state returns to reset values immediately. No further BRAM_WE. The partial frame is abandoned.

Optional Feature:
- Macro: FRAME_CAPTURE_SUM_EN.
- Defined:
  - FRAME_SUM accumulates TDATA[31:0] + TDATA[63:32] over every written word of the frame, modulo 2^32.
  - It is cleared at frame start and latched at FRAME_DONE; the latched value holds until the next FRAME_DONE.
  - Short and long frames do not update FRAME_SUM.
- Undefined: FRAME_SUM is tied to 0 and no accumulator logic exists.

Test Plan:
- Good frame: ENABLE=1, 1024 back-to-back words with data = index and TLAST on word 1023 → writes to addresses 0..1023; FRAME_DONE=1 with DONE_BANK=0; BANK_FULL=2'b01; FRAME_COUNT=1. With the macro defined, FRAME_SUM=1047552.
- Ping-pong backpressure: send 3 good frames with no release → frame 2 goes to addresses 1024..2047; TREADY=0 after frame 2. Pulse BANK_RELEASE=2'b01 → TREADY=1 the next cycle and frame 3 is written at address 0.
- Short frame: TLAST on word 99 → ERR_SHORT=1, no FRAME_DONE, FRAME_COUNT unchanged; the next good frame is written starting at address 0.
- Long frame: 1100 words with TLAST on word 1099 → ERR_LONG=1, exactly 1024 writes, words 1024..1099 accepted but not written, no FRAME_DONE.
- Stalls and ENABLE drop: random TVALID gaps, with ENABLE lowered at word 500 → the frame completes with 1024 writes, FRAME_DONE is pulsed, then TREADY=0 in IDLE.
- Mid-frame reset: S_AXIS_ARESETN=0 at word 300 → the next cycle shows TREADY=0, BRAM_WE=0, all flags and counters 0.

Source files
------------

// File: rtl/frame_capture_s_axis.sv
// AXI-Stream frame capture into a ping-pong BRAM region; optional checksum under FRAME_CAPTURE_SUM_EN.
// Latency: BRAM write 1 cycle after transfer, FRAME_DONE 1 cycle after the last write.
// Backpressure: TREADY low in IDLE, WAIT_BANK and the frame-completion cycle; never depends on TVALID.
module frame_capture_s_axis #(
    parameter int BRAM_DEPTH_BITS      = 11,
    parameter int C_S_AXIS_TDATA_WIDTH = 64,
    parameter int FRAME_WORDS          = 1024
) (
    input  logic                              S_AXIS_ACLK,
    input  logic                              S_AXIS_ARESETN,
    input  logic                              S_AXIS_TVALID,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
    input  logic                              S_AXIS_TLAST,
    output logic                              S_AXIS_TREADY,
    input  logic                              ENABLE,
    input  logic [1:0]                        BANK_RELEASE,
    input  logic                              CLEAR_ERR,
    output logic [BRAM_DEPTH_BITS-1:0]        BRAM_ADDR,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]   BRAM_DATAOUT,
    output logic                              BRAM_WE,
    output logic                              FRAME_DONE,
    output logic                              DONE_BANK,
    output logic [1:0]                        BANK_FULL,
    output logic [31:0]                       FRAME_COUNT,
    output logic                              ERR_SHORT,
    output logic                              ERR_LONG,
    output logic [31:0]                       FRAME_SUM
);
    localparam int AW = BRAM_DEPTH_BITS;
    localparam int CW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [CW-1:0] LAST_IDX   = CW'(FRAME_WORDS - 1);
    localparam logic [AW-1:0] BANK1_BASE = AW'(FRAME_WORDS);

    typedef enum logic [1:0] {IDLE, CAPTURE, DROP, WAIT_BANK} state_t;

    state_t        state, state_next;
    logic          active_bank;
    logic          done_pend;
    logic [CW-1:0] word_ctr;
    logic [1:0]    bank_full;
    logic [1:0]    set_mask;
    logic [AW-1:0] wr_addr;
    logic          xfer, capture_xfer, at_last;
    logic          good_end, short_end, long_end;
    logic          next_bank_busy;
    logic          unused_strb;

    assign unused_strb = ^S_AXIS_TSTRB;

    // done_pend holds off the stream for the single cycle in which the bank swaps
    assign S_AXIS_TREADY = ((state == CAPTURE) && !done_pend) || (state == DROP);

    assign xfer         = S_AXIS_TVALID && S_AXIS_TREADY;
    assign capture_xfer = xfer && (state == CAPTURE);
    assign at_last      = (word_ctr == LAST_IDX);
    assign good_end     = capture_xfer && at_last && S_AXIS_TLAST;
    assign short_end    = capture_xfer && !at_last && S_AXIS_TLAST;
    assign long_end     = capture_xfer && at_last && !S_AXIS_TLAST;
    assign set_mask     = done_pend ? (active_bank ? 2'b10 : 2'b01) : 2'b00;
    assign wr_addr      = active_bank ? (BANK1_BASE + AW'(word_ctr)) : AW'(word_ctr);
    assign next_bank_busy = bank_full[~active_bank] && !BANK_RELEASE[~active_bank];
    assign BANK_FULL    = bank_full;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (ENABLE)
                    state_next = bank_full[active_bank] ? WAIT_BANK : CAPTURE;
            end
            CAPTURE: begin
                if (done_pend) begin
                    if (next_bank_busy)
                        state_next = WAIT_BANK;
                    else if (!ENABLE)
                        state_next = IDLE;
                end else if (long_end) begin
                    state_next = DROP;
                end else if (short_end && !ENABLE) begin
                    state_next = IDLE;
                end else if (!xfer && (word_ctr == '0) && !ENABLE) begin
                    state_next = IDLE;
                end
            end
            DROP: begin
                if (xfer && S_AXIS_TLAST)
                    state_next = ENABLE ? CAPTURE : IDLE;
            end
            WAIT_BANK: begin
                if (!bank_full[active_bank] || BANK_RELEASE[active_bank])
                    state_next = ENABLE ? CAPTURE : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge S_AXIS_ACLK) begin
        if (!S_AXIS_ARESETN) begin
            state        <= IDLE;
            active_bank  <= 1'b0;
            done_pend    <= 1'b0;
            word_ctr     <= '0;
            bank_full    <= 2'b00;
            BRAM_WE      <= 1'b0;
            BRAM_ADDR    <= '0;
            BRAM_DATAOUT <= '0;
            FRAME_DONE   <= 1'b0;
            DONE_BANK    <= 1'b0;
            FRAME_COUNT  <= 32'd0;
            ERR_SHORT    <= 1'b0;
            ERR_LONG     <= 1'b0;
        end else begin
            state      <= state_next;
            done_pend  <= good_end;
            BRAM_WE    <= capture_xfer;
            FRAME_DONE <= done_pend;
            bank_full  <= (bank_full & ~BANK_RELEASE) | set_mask;
            // a new error outranks a simultaneous clear
            ERR_SHORT  <= short_end | (ERR_SHORT & ~CLEAR_ERR);
            ERR_LONG   <= long_end | (ERR_LONG & ~CLEAR_ERR);
            if (capture_xfer) begin
                BRAM_ADDR    <= wr_addr;
                BRAM_DATAOUT <= S_AXIS_TDATA;
                if (!good_end)
                    word_ctr <= (S_AXIS_TLAST || at_last) ? '0 : word_ctr + CW'(1);
            end
            if (done_pend) begin
                DONE_BANK   <= active_bank;
                FRAME_COUNT <= FRAME_COUNT + 32'd1;
                active_bank <= ~active_bank;
                word_ctr    <= '0;
            end
        end
    end

`ifdef FRAME_CAPTURE_SUM_EN
    logic [31:0] sum_acc;
    logic [31:0] sum_hold;

    always_ff @(posedge S_AXIS_ACLK) begin
        if (!S_AXIS_ARESETN) begin
            sum_acc  <= 32'd0;
            sum_hold <= 32'd0;
        end else begin
            if (capture_xfer)
                sum_acc <= ((word_ctr == '0) ? 32'd0 : sum_acc)
                         + S_AXIS_TDATA[31:0] + S_AXIS_TDATA[63:32];
            if (done_pend)
                sum_hold <= sum_acc;
        end
    end

    assign FRAME_SUM = sum_hold;
`else
    assign FRAME_SUM = 32'd0;
`endif

endmodule

// File: tb/tb_frame_capture_s_axis.sv
// Bench for frame_capture_s_axis: frame-level reference model checked every cycle plus directed literal checks.
`timescale 1ns/1ps
module tb_frame_capture_s_axis;
    localparam int FW = 1024;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tvalid;
    logic [63:0] tdata;
    logic [7:0]  tstrb;
    logic        tlast;
    logic        tready;
    logic        enable;
    logic [1:0]  bank_release;
    logic        clear_err;
    logic [10:0] bram_addr;
    logic [63:0] bram_dataout;
    logic        bram_we;
    logic        frame_done;
    logic        done_bank;
    logic [1:0]  bank_full;
    logic [31:0] frame_count;
    logic        err_short;
    logic        err_long;
    logic [31:0] frame_sum;

    frame_capture_s_axis dut (
        .S_AXIS_ACLK   (clk),
        .S_AXIS_ARESETN(rst_n),
        .S_AXIS_TVALID (tvalid),
        .S_AXIS_TDATA  (tdata),
        .S_AXIS_TSTRB  (tstrb),
        .S_AXIS_TLAST  (tlast),
        .S_AXIS_TREADY (tready),
        .ENABLE        (enable),
        .BANK_RELEASE  (bank_release),
        .CLEAR_ERR     (clear_err),
        .BRAM_ADDR     (bram_addr),
        .BRAM_DATAOUT  (bram_dataout),
        .BRAM_WE       (bram_we),
        .FRAME_DONE    (frame_done),
        .DONE_BANK     (done_bank),
        .BANK_FULL     (bank_full),
        .FRAME_COUNT   (frame_count),
        .ERR_SHORT     (err_short),
        .ERR_LONG      (err_long),
        .FRAME_SUM     (frame_sum)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_on = 1'b0;
    int wr_total = 0;
    int done_total = 0;
    logic [10:0] last_addr = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: what the outputs must show during the current cycle
    logic        exp_we = 0, exp_done = 0, exp_dbank = 0, exp_es = 0, exp_el = 0;
    logic [10:0] exp_addr = '0;
    logic [63:0] exp_data = '0;
    logic [1:0]  exp_full = '0;
    logic [31:0] exp_cnt = '0, exp_fsum = '0;
    bit          m_drop = 0, m_bank = 0, pend = 0, pend_bank = 0;
    int          m_idx = 0;
    logic [31:0] m_sum = '0, pend_sum = '0;

    always @(negedge clk) begin
        logic n_we, n_done;
        if (mon_on) begin
            chk("BRAM_WE", bram_we, exp_we);
            if (exp_we) begin
                chk("BRAM_ADDR", bram_addr, exp_addr);
                chk("BRAM_DATAOUT", bram_dataout, exp_data);
            end
            chk("FRAME_DONE", frame_done, exp_done);
            if (exp_done) chk("DONE_BANK", done_bank, exp_dbank);
            chk("BANK_FULL", bank_full, exp_full);
            chk("FRAME_COUNT", frame_count, exp_cnt);
            chk("ERR_SHORT", err_short, exp_es);
            chk("ERR_LONG", err_long, exp_el);
            chk("FRAME_SUM", frame_sum, exp_fsum);
            if (bram_we === 1'b1) begin wr_total++; last_addr = bram_addr; end
            if (frame_done === 1'b1) done_total++;

            n_we = 0;
            n_done = 0;
            if (!rst_n) begin
                exp_addr = '0; exp_data = '0; exp_dbank = 0; exp_full = '0; exp_cnt = '0;
                exp_es = 0; exp_el = 0; exp_fsum = '0;
                m_drop = 0; m_bank = 0; m_idx = 0; m_sum = '0; pend = 0;
            end else begin
                exp_full = exp_full & ~bank_release;
                if (clear_err) begin exp_es = 0; exp_el = 0; end
                if (pend) begin
                    n_done = 1;
                    exp_dbank = pend_bank;
                    exp_cnt = exp_cnt + 1;
                    exp_full[pend_bank] = 1'b1;
`ifdef FRAME_CAPTURE_SUM_EN
                    exp_fsum = pend_sum;
`endif
                    pend = 0;
                end
                if (tvalid && tready) begin
                    if (m_drop) begin
                        if (tlast) m_drop = 0;
                    end else begin
                        if (exp_full[m_bank]) chk("ACCEPT_INTO_FULL_BANK", 1, 0);
                        n_we = 1;
                        exp_addr = 11'(m_bank ? FW + m_idx : m_idx);
                        exp_data = tdata;
                        m_sum = ((m_idx == 0) ? 32'd0 : m_sum) + tdata[31:0] + tdata[63:32];
                        if (m_idx == FW - 1) begin
                            if (tlast) begin
                                pend = 1; pend_bank = m_bank; pend_sum = m_sum; m_bank = ~m_bank;
                            end else begin
                                exp_el = 1; m_drop = 1;
                            end
                            m_idx = 0;
                        end else if (tlast) begin
                            exp_es = 1; m_idx = 0;
                        end else begin
                            m_idx++;
                        end
                    end
                end
            end
            exp_we = n_we;
            exp_done = n_done;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [63:0] d, input bit last, input int gap_max);
        bit hs;
        int cycles;
        if (gap_max > 0 && $urandom_range(0, 3) == 0) begin
            tvalid = 0;
            idle($urandom_range(1, gap_max));
        end
        tvalid = 1; tdata = d; tlast = last; tstrb = 8'($urandom);
        cycles = 0;
        do begin
            @(negedge clk);
            hs = tready;
            @(posedge clk);
            #1;
            cycles++;
        end while (!hs && cycles < 3000);
        if (!hs) chk("TREADY_TIMEOUT", 0, 1);
        tvalid = 0; tlast = 0;
    endtask

    task automatic send_frame(input int n, input int last_idx, input bit idx_data,
                              input int gap_max, input int en_drop_at);
        logic [63:0] d;
        for (int i = 0; i < n; i++) begin
            if (i == en_drop_at) enable = 0;
            d = idx_data ? {32'(i), 32'(i)} : {$urandom, $urandom};
            send_word(d, i == last_idx, gap_max);
        end
    endtask

    task automatic pulse_release(input logic [1:0] b);
        bank_release = b;
        idle(1);
        bank_release = 2'b00;
    endtask

    initial begin
        int w0, d0;
        rst_n = 0; tvalid = 0; tdata = '0; tstrb = '0; tlast = 0;
        enable = 0; bank_release = 2'b00; clear_err = 0;
        idle(3);
        mon_on = 1;
        idle(2);
        rst_n = 1;
        idle(2);
        chk("RESET_TREADY", tready, 0);
        chk("RESET_WE", bram_we, 0);
        chk("RESET_FULL", bank_full, 0);
        chk("RESET_COUNT", frame_count, 0);

        // good frame, index data, back to back
        enable = 1;
        idle(1);
        send_frame(FW, FW - 1, 1, 0, -1);
        idle(2);
        chk("GOOD_COUNT", frame_count, 1);
        chk("GOOD_FULL", bank_full, 2'b01);
        chk("GOOD_LAST_ADDR", last_addr, 1023);
        chk("GOOD_DONES", done_total, 1);
`ifdef FRAME_CAPTURE_SUM_EN
        chk("GOOD_SUM", frame_sum, 1047552);
`else
        chk("GOOD_SUM", frame_sum, 0);
`endif

        // second frame fills bank 1, then the block must stall
        send_frame(FW, FW - 1, 0, 0, -1);
        idle(3);
        chk("PP_LAST_ADDR", last_addr, 2047);
        chk("PP_FULL", bank_full, 2'b11);
        chk("PP_STALL", tready, 0);
        idle(4);
        chk("PP_STALL_HOLD", tready, 0);
        bank_release = 2'b01;
        idle(1);
        bank_release = 2'b00;
        chk("PP_RELEASE_READY", tready, 1);
        send_frame(FW, FW - 1, 0, 3, -1);
        idle(2);
        chk("PP_F3_LAST_ADDR", last_addr, 1023);
        chk("PP_F3_COUNT", frame_count, 3);
        pulse_release(2'b11);

        // short frame on bank 1, then clear, then a good frame in the same bank
        send_frame(100, 99, 0, 0, -1);
        idle(2);
        chk("SHORT_ERR", err_short, 1);
        chk("SHORT_COUNT", frame_count, 3);
        chk("SHORT_DONES", done_total, 3);
        clear_err = 1;
        idle(1);
        clear_err = 0;
        chk("SHORT_CLEARED", err_short, 0);
        send_frame(FW, FW - 1, 0, 2, -1);
        idle(2);
        chk("AFTER_SHORT_LAST_ADDR", last_addr, 2047);
        chk("AFTER_SHORT_COUNT", frame_count, 4);
        pulse_release(2'b10);

        // long frame: only the first FW words get written
        w0 = wr_total;
        send_frame(1100, 1099, 0, 0, -1);
        idle(3);
        chk("LONG_WRITES", wr_total - w0, FW);
        chk("LONG_ERR", err_long, 1);
        chk("LONG_COUNT", frame_count, 4);
        chk("LONG_DONES", done_total, 4);

        // random stalls with ENABLE dropped mid-frame
        d0 = done_total;
        w0 = wr_total;
        send_frame(FW, FW - 1, 0, 4, 500);
        idle(4);
        chk("EN_DROP_WRITES", wr_total - w0, FW);
        chk("EN_DROP_DONE", done_total - d0, 1);
        chk("EN_DROP_IDLE", tready, 0);
        idle(5);
        chk("EN_DROP_IDLE_HOLD", tready, 0);

        // reset in the middle of a frame
        pulse_release(2'b11);
        enable = 1;
        idle(2);
        send_frame(300, -1, 0, 0, -1);
        rst_n = 0;
        idle(1);
        chk("MIDRST_TREADY", tready, 0);
        chk("MIDRST_WE", bram_we, 0);
        chk("MIDRST_FULL", bank_full, 0);
        chk("MIDRST_COUNT", frame_count, 0);
        chk("MIDRST_ERR_LONG", err_long, 0);
        rst_n = 1;
        idle(2);
        send_frame(FW, FW - 1, 0, 2, -1);
        idle(3);
        chk("POSTRST_COUNT", frame_count, 1);
        chk("POSTRST_LAST_ADDR", last_addr, 1023);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d, mismatched %0d", n_cmp, n_bad);
        $fatal(1);
    end
endmodule
